uart_rx_fifo: RTL

Receive-side byte buffer that sits directly downstream of the UART receiver. It watches the receiver's `received` level and data bus, and captures each newly completed byte exactly once into a synchronous FIFO. It presents the bytes to the system logic through a first-word-fall-through read port. The `received` level originates in the baud-derived clock domain, so the block resynchronises it before edge detection.

---
 rtl/uart_rx_fifo.sv | 77 +++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: resynchronises the "byte complete" level,
// captures each new byte once on its rising edge, and serves it through a FWFT read port.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_received,
    input  logic                  rd_en,
    input  logic                  clr_overflow,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic                  sync1, sync2, sync3;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push, pop, wr_en, ovf_set;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    assign push    = sync2 & ~sync3;
    assign pop     = rd_en & ~empty;
    // A push into a full FIFO only lands when a pop frees the head slot in the same edge.
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make this a true three-stage shift, not one flop.
            sync1 <= rx_received;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;

            if (wr_en && !pop)      count <= count + CNT_ONE;
            else if (pop && !wr_en) count <= count - CNT_ONE;

            if (ovf_set)           overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

endmodule
